// File: rtl/lmfe_pkg.sv
// -----------------------------------------------------------------------------
// lmfe_pkg
// Shared constants and types for the LMFE pixel path. The image geometry and
// the feeder FSM state type are used by the feeder, the LMFE core and benches.
//   DATA_W  pixel width
//   IMG_W   pixels per row
//   IMG_H   rows per frame
//   ADDR_W  SRAM address width (2**ADDR_W >= IMG_W*IMG_H)
//   N_PIX   pixels per frame
// -----------------------------------------------------------------------------
package lmfe_pkg;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int N_PIX  = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lmfe_pixel_feeder_if.sv
// -----------------------------------------------------------------------------
// lmfe_pixel_feeder_if
// Bundles the two buses of the pixel feeder:
//   pixel bus : in_en, Din (feeder -> LMFE), busy (LMFE -> feeder)
//   SRAM bus  : mem_ren, mem_addr (feeder -> SRAM), mem_rdata (SRAM -> feeder)
// Modports:
//   master : the feeder (drives in_en/Din/mem_ren/mem_addr)
//   slave  : the LMFE core plus SRAM side (drives busy/mem_rdata)
//
// Handshake: a pixel moves at every rising edge where in_en=1. busy is an
// inverted ready; in_en is never asserted while busy=1, so in_en alone marks
// a transfer. Din is only meaningful when in_en=1. mem_rdata is valid in the
// cycle after a cycle with mem_ren=1 (1-cycle read latency).
// -----------------------------------------------------------------------------
interface lmfe_pixel_feeder_if
  import lmfe_pkg::*;
#(
  parameter int DATA_W = lmfe_pkg::DATA_W,
  parameter int ADDR_W = lmfe_pkg::ADDR_W
);

  logic              busy;
  logic              in_en;
  logic [DATA_W-1:0] Din;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  busy,
    output in_en,
    output Din,
    output mem_ren,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    output busy,
    input  in_en,
    input  Din,
    input  mem_ren,
    input  mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/lmfe_feed_fifo.sv
// -----------------------------------------------------------------------------
// lmfe_feed_fifo
// Two-entry FIFO sitting between the SRAM read data and the pixel bus.
// Simultaneous push and pop are allowed. The caller guarantees no push when
// full and no pop when empty (the feeder's read credit rule ensures this).
// Ports:
//   clk, reset  clock, synchronous active-high reset (flushes the FIFO)
//   push        write push_data at this edge
//   push_data   data to write
//   pop         drop the head entry at this edge
//   head        oldest entry (valid when occ != 0)
//   occ         number of valid entries, 0..2
// -----------------------------------------------------------------------------
module lmfe_feed_fifo
  import lmfe_pkg::*;
#(
  parameter int DATA_W = lmfe_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;

endmodule

// File: rtl/lmfe_pixel_feeder.sv
// -----------------------------------------------------------------------------
// lmfe_pixel_feeder
// Streams a raster-order frame from a 1-cycle-latency SRAM to the LMFE core,
// one pixel per cycle when busy is low, stalling cleanly under busy.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      frame start request, sampled only in IDLE
//   bus        master side of lmfe_pixel_feeder_if (pixel bus + SRAM bus)
//   active     high while the FSM is in RUN
//   done       one-cycle pulse (the DONE state) after the last transfer
//   state_dbg  current FSM state, for observation only
// -----------------------------------------------------------------------------
module lmfe_pixel_feeder
  import lmfe_pkg::*;
#(
  parameter int DATA_W = lmfe_pkg::DATA_W,
  parameter int IMG_W  = lmfe_pkg::IMG_W,
  parameter int IMG_H  = lmfe_pkg::IMG_H,
  parameter int ADDR_W = lmfe_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  lmfe_pixel_feeder_if.master  bus,
  output logic                 active,
  output logic                 done,
  output state_t               state_dbg
);

  // One extra bit so the counters can hold the full pixel count itself
  // (e.g. 16384 does not fit in 14 bits).
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_W * IMG_H);
  localparam logic [CNT_W-1:0] LAST_XFER = CNT_W'(IMG_W * IMG_H - 1);

  state_t             state_q;
  logic               active_q;
  logic               done_q;
  logic               inflight_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic [CNT_W-1:0]   xfer_cnt_q;
  logic [DATA_W-1:0]  last_q;

  logic [DATA_W-1:0]  head;
  logic [1:0]         occ;
  logic               fifo_nonempty;
  logic               pop;
  logic               ren;
  logic [2:0]         credit;

  assign fifo_nonempty = (occ != 2'd0);

  // A transfer is a pop; it depends combinationally on busy so that a busy
  // release is answered in the same cycle.
  assign pop = fifo_nonempty & ~bus.busy;

  // Entries that will be held after this edge if no new read is issued:
  // what is buffered, plus the read returning now, minus what leaves now.
  // Issuing only while this is below 2 keeps the 2-entry FIFO from overflowing.
  assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  assign ren = (state_q == ST_RUN) && (rd_cnt_q < FRAME_PIX) && (credit < 3'd2);

  lmfe_feed_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (bus.mem_rdata),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      rd_cnt_q   <= '0;
      xfer_cnt_q <= '0;
      last_q     <= '0;
    end else begin
      inflight_q <= ren;
      done_q     <= 1'b0;
      if (pop) begin
        last_q     <= head;
        xfer_cnt_q <= xfer_cnt_q + 1'b1;
      end
      if (ren) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            active_q   <= 1'b1;
            rd_cnt_q   <= '0;
            xfer_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (pop && (xfer_cnt_q == LAST_XFER)) begin
            state_q  <= ST_DONE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_en    = pop;
  // Between transfers Din keeps showing the last pixel that moved.
  assign bus.Din      = fifo_nonempty ? head : last_q;
  assign bus.mem_ren  = ren;
  assign bus.mem_addr = rd_cnt_q[ADDR_W-1:0];

  assign active    = active_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// -----------------------------------------------------------------------------
// tb_lmfe_pixel_feeder
// Bench for lmfe_pixel_feeder: a full-size instance (128x128) and a small
// 4x2 instance, each with an SRAM model holding SRAM[k] = k[7:0]. The expected
// pixel stream of a frame is the SRAM contents in address order, held in a
// queue and consumed transfer by transfer.
// -----------------------------------------------------------------------------
module tb_lmfe_pixel_feeder;
  import lmfe_pkg::*;

  localparam int NP   = N_PIX;
  localparam int NP_S = 8;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  logic   start, start_s;
  logic   active, done, active_s, done_s;
  state_t state_dbg, state_dbg_s;

  always #5 clk = ~clk;

  lmfe_pixel_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus   ();
  lmfe_pixel_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_s ();

  lmfe_pixel_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .active    (active),
    .done      (done),
    .state_dbg (state_dbg)
  );

  lmfe_pixel_feeder #(.IMG_W(4), .IMG_H(2)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .start     (start_s),
    .bus       (bus_s),
    .active    (active_s),
    .done      (done_s),
    .state_dbg (state_dbg_s)
  );

  // ---------------- SRAM models (1-cycle latency) ----------------
  logic [DATA_W-1:0] sram [NP];

  always @(posedge clk) begin
    bus.mem_rdata   <= (bus.mem_ren === 1'b1)   ? sram[bus.mem_addr]   : DATA_W'($urandom);
    bus_s.mem_rdata <= (bus_s.mem_ren === 1'b1) ? sram[bus_s.mem_addr] : DATA_W'($urandom);
  end

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cnt, xfer_cnt, done_cnt, first_xfer, last_xfer, done_cyc;
  int rd_cnt_s, xfer_cnt_s, done_cnt_s, last_addr_s;
  int busy_mode;       // 0: busy driven by directed steps, 1: random 50%
  bit alt_s_on;        // small instance: busy toggles every cycle
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_s_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample both DUTs at the falling edge; transfers seen here complete at the
  // next rising edge.
  task automatic to_neg();
    logic [DATA_W-1:0] e;
    @(negedge clk);
    if (reset === 1'b0) begin
      if (bus.mem_ren === 1'b1) begin
        check("mem_addr_order", 32'(bus.mem_addr), rd_cnt);
        rd_cnt++;
      end
      if (bus.in_en === 1'b1) begin
        check("in_en_while_busy", 32'(bus.busy), 0);
        check("active_during_xfer", 32'(active), 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        check("din_vs_sram_order", 32'(bus.Din), 32'(e));
        if (xfer_cnt == 0) first_xfer = cyc;
        last_xfer = cyc;
        xfer_cnt++;
      end
      if (done === 1'b1) begin
        check("active_low_in_done", 32'(active), 0);
        check("state_done", 32'(state_dbg), 32'(ST_DONE));
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus_s.mem_ren === 1'b1) begin
        check("s_mem_addr_order", 32'(bus_s.mem_addr), rd_cnt_s);
        check("s_addr_in_frame", 32'(bus_s.mem_addr < NP_S), 1);
        last_addr_s = int'(bus_s.mem_addr);
        rd_cnt_s++;
      end
      if (bus_s.in_en === 1'b1) begin
        check("s_in_en_while_busy", 32'(bus_s.busy), 0);
        if (exp_s_q.size() > 0) e = exp_s_q.pop_front();
        else e = 'x;
        check("s_din_vs_sram_order", 32'(bus_s.Din), 32'(e));
        xfer_cnt_s++;
      end
      if (done_s === 1'b1) done_cnt_s++;
    end
  endtask

  // Advance to just after the rising edge and drive the next cycle's inputs.
  task automatic to_pos();
    @(posedge clk);
    cyc++;
    #1;
    if (busy_mode == 1) bus.busy = 1'($urandom_range(0, 1));
    if (alt_s_on) bus_s.busy = ~bus_s.busy;
  endtask

  task automatic cycle();
    to_neg();
    to_pos();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    exp_q.delete();
    for (int k = 0; k < NP; k++) exp_q.push_back(sram[k]);
    rd_cnt = 0; xfer_cnt = 0; done_cnt = 0; first_xfer = -1; last_xfer = -1; done_cyc = -1;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_xfer(input int n, input int limit);
    int g = 0;
    while (xfer_cnt < n && g < limit) begin
      cycle();
      g++;
    end
    check("reach_xfer_count", xfer_cnt, n);
  endtask

  task automatic wait_done(input int limit);
    int g = 0;
    while (done_cnt == 0 && g < limit) begin
      cycle();
      g++;
    end
    check("done_seen_in_budget", 32'(done_cnt != 0), 1);
  endtask

  task automatic end_frame();
    check("frame_xfer_count", xfer_cnt, NP);
    check("done_one_after_last", done_cyc, last_xfer + 1);
    check("sram_order_exhausted", exp_q.size(), 0);
    repeat (3) cycle();
    check("single_done", done_cnt, 1);
    check("back_to_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("active_idle", 32'(active), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_en"},    32'(bus.in_en), 0);
    check({tag, "_din"},      32'(bus.Din), 0);
    check({tag, "_mem_ren"},  32'(bus.mem_ren), 0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    check({tag, "_active"},   32'(active), 0);
    check({tag, "_done"},     32'(done), 0);
    check({tag, "_state"},    32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < NP; k++) sram[k] = DATA_W'(k);
    reset = 1'b1; start = 1'b0; start_s = 1'b0;
    busy_mode = 0; alt_s_on = 1'b0;
    bus.busy = 1'b0; bus_s.busy = 1'b0;
    rd_cnt = 0; xfer_cnt = 0; done_cnt = 0; first_xfer = -1; last_xfer = -1; done_cyc = -1;
    rd_cnt_s = 0; xfer_cnt_s = 0; done_cnt_s = 0; last_addr_s = -1;

    repeat (3) cycle();
    reset = 1'b0;

    // Reset state
    to_neg();
    check_all_zero("reset");
    check("s_reset_in_en", 32'(bus_s.in_en), 0);
    check("s_reset_done", 32'(done_s), 0);
    to_pos();

    // Small 4x2 frame with busy alternating every cycle
    for (int k = 0; k < NP_S; k++) exp_s_q.push_back(sram[k]);
    bus_s.busy = 1'b1;
    alt_s_on = 1'b1;
    start_s = 1'b1;
    cycle();
    start_s = 1'b0;
    for (int g = 0; g < 200 && done_cnt_s == 0; g++) cycle();
    check("s_done_seen", done_cnt_s, 1);
    check("s_xfer_count", xfer_cnt_s, NP_S);
    check("s_read_count", rd_cnt_s, NP_S);
    check("s_last_mem_addr", last_addr_s, NP_S - 1);
    repeat (2) cycle();
    check("s_back_idle", 32'(state_dbg_s), 32'(ST_IDLE));
    check("s_single_done", done_cnt_s, 1);
    alt_s_on = 1'b0;
    bus_s.busy = 1'b0;

    // Frame A: busy low, latency and contiguous streaming
    start_frame();
    to_neg();
    check("lat_c1_mem_ren", 32'(bus.mem_ren), 1);
    check("lat_c1_mem_addr", 32'(bus.mem_addr), 0);
    check("lat_c1_in_en", 32'(bus.in_en), 0);
    check("lat_c1_active", 32'(active), 1);
    to_pos();
    to_neg();
    check("lat_c2_in_en", 32'(bus.in_en), 0);
    to_pos();
    to_neg();
    check("lat_c3_in_en", 32'(bus.in_en), 1);
    check("lat_c3_din", 32'(bus.Din), 32'(sram[0]));
    to_pos();
    wait_done(NP + 100);
    check("contiguous_stream", last_xfer - first_xfer, NP - 1);
    end_frame();

    // Frame B: start re-pulsed mid-frame, busy held 50 cycles at pixel 1000
    start_frame();
    wait_xfer(200, 400);
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_xfer(1000, 1200);
    bus.busy = 1'b1;
    repeat (49) cycle();
    to_neg();
    check("hold_mem_ren_stopped", 32'(bus.mem_ren), 0);
    check("hold_outstanding_le2", 32'((rd_cnt - xfer_cnt) <= 2), 1);
    check("hold_xfer_frozen", xfer_cnt, 1000);
    check("hold_in_en_low", 32'(bus.in_en), 0);
    to_pos();
    bus.busy = 1'b0;
    to_neg();
    check("release_in_en", 32'(bus.in_en), 1);
    check("release_din", 32'(bus.Din), 1000 & 8'hFF);
    to_pos();
    wait_done(NP + 200);
    end_frame();

    // Frame C: reset for one cycle at pixel 5000
    start_frame();
    wait_xfer(5000, 5200);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    to_neg();
    check_all_zero("midreset");
    to_pos();
    exp_q.delete();
    repeat (3) cycle();

    // Frame D: full frame after reset with random 50% busy
    busy_mode = 1;
    start_frame();
    wait_done(3 * NP);
    busy_mode = 0;
    bus.busy = 1'b0;
    end_frame();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
